// File: rtl/switch_led_sequencer_if.sv
// Front-panel bundle: raw switches toward the sequencer, LED drive and step pulse back.
interface switch_led_sequencer_if #(
  parameter int NUM_SW  = 8,
  parameter int NUM_LED = 8
);
  logic [NUM_SW-1:0]  switch;
  logic [NUM_LED-1:0] led;
  logic               tick;

  modport master (output switch, input led, input tick);
  modport slave  (input switch, output led, output tick);
endinterface

// File: rtl/switch_led_sequencer.sv
// Debounced slide switches select a static mirror, counter, chaser or blink pattern
// on the LEDs; pattern modes advance on a divided tick with pause and direction.
module switch_led_sequencer #(
  parameter int NUM_SW          = 8,
  parameter int NUM_LED         = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 25000000
) (
  input logic                   clk,
  input logic                   rst,
  switch_led_sequencer_if.slave bus
);
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_COUNT  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  logic [NUM_SW-1:0]  sync1_reg, sync2_reg, sw_db;
  logic [TICK_W-1:0]  tick_cnt_reg, tick_cnt_next;
  logic [NUM_LED-1:0] pattern_reg, pattern_next;
  logic [NUM_LED-1:0] blink_init, static_led;
  mode_e              mode, mode_q_reg, mode_next;
  logic               pause, dir, tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.switch;
      sync2_reg <= sync1_reg;
    end
  end

  // Each bit has its own stability counter so one bouncing switch cannot delay another.
  generate
    for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_debounce
      logic            db_reg;
      logic [DB_W-1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          db_reg  <= 1'b0;
          cnt_reg <= '0;
        end else if (sync2_reg[gi] == db_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_MAX) begin
          db_reg  <= sync2_reg[gi];
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end

      assign sw_db[gi] = db_reg;
    end

    for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_led_map
      assign blink_init[gi] = ((gi % 2) == 0) ? 1'b1 : 1'b0;
      if (gi < NUM_SW) begin : g_sw
        assign static_led[gi] = sw_db[gi];
      end else begin : g_zero
        assign static_led[gi] = 1'b0;
      end
    end
  endgenerate

  assign mode  = mode_e'(sw_db[1:0]);
  assign pause = sw_db[2];
  assign dir   = sw_db[3];
  assign tick  = (tick_cnt_reg == TICK_MAX) && !pause;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q_reg   <= MODE_STATIC;
      tick_cnt_reg <= '0;
      pattern_reg  <= '0;
    end else begin
      mode_q_reg   <= mode_next;
      tick_cnt_reg <= tick_cnt_next;
      pattern_reg  <= pattern_next;
    end
  end

  // A mode change restarts the pattern and tick phase and overrides any step due this cycle.
  always_comb begin
    mode_next     = mode_q_reg;
    tick_cnt_next = tick_cnt_reg;
    pattern_next  = pattern_reg;
    if (mode != mode_q_reg) begin
      mode_next     = mode;
      tick_cnt_next = '0;
      case (mode)
        MODE_CHASE: pattern_next = NUM_LED'(1);
        MODE_BLINK: pattern_next = blink_init;
        default:    pattern_next = '0;
      endcase
    end else begin
      if (!pause) begin
        tick_cnt_next = (tick_cnt_reg == TICK_MAX) ? '0 : tick_cnt_reg + TICK_W'(1);
      end
      if (tick) begin
        case (mode_q_reg)
          MODE_COUNT: pattern_next = dir ? pattern_reg - NUM_LED'(1)
                                         : pattern_reg + NUM_LED'(1);
          MODE_CHASE: pattern_next = dir ? {pattern_reg[0], pattern_reg[NUM_LED-1:1]}
                                         : {pattern_reg[NUM_LED-2:0], pattern_reg[NUM_LED-1]};
          MODE_BLINK: pattern_next = ~pattern_reg;
          default:    pattern_next = pattern_reg;
        endcase
      end
    end
  end

  assign bus.led  = (mode_q_reg == MODE_STATIC) ? static_led : pattern_reg;
  assign bus.tick = tick;
endmodule
